// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-RAM write port of the image loader.
// The master (host link) drives the stream. The slave (loader) drives the RAM and status outputs.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction RAM: SYNC, LEN_LO, LEN_HI, data, CHK.
// Holds the core while an image is written and pulses done or err when the frame ends.
module imem_loader #(
    parameter int         ADDR_W = 8,
    parameter int         DEPTH  = 128,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t            state, nxt;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       cnt;
    logic [7:0]        sum;
    logic              hold;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              rdy;
    logic              acc;
    logic [15:0]       len_w;
    logic [15:0]       cnt_inc;
    logic              chk_ok;

    // DONE and ERR are one-cycle pulse states in which no byte is taken.
    assign rdy     = rst_n && (state != S_DONE) && (state != S_ERR);
    assign acc     = bus.in_valid && rdy;
    assign len_w   = {bus.in_data, len_lo};
    assign cnt_inc = cnt + 16'd1;
    assign chk_ok  = (sum + bus.in_data) == 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (acc && bus.in_data == SYNC) nxt = S_LEN0;
            S_LEN0: if (acc) nxt = S_LEN1;
            S_LEN1: if (acc) begin
                if (len_w > DEPTH16)    nxt = S_ERR;
                else if (len_w == 16'd0) nxt = S_CHK;
                else                     nxt = S_DATA;
            end
            S_DATA: if (acc && cnt_inc == len) nxt = S_CHK;
            S_CHK:  if (acc) nxt = chk_ok ? S_DONE : S_ERR;
            S_DONE: nxt = S_IDLE;
            S_ERR:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo <= '0;
            len    <= '0;
            cnt    <= '0;
            sum    <= '0;
            hold   <= 1'b0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
        end else begin
            we <= 1'b0;
            if (acc) begin
                case (state)
                    S_IDLE: if (bus.in_data == SYNC) begin
                        hold <= 1'b1;
                        sum  <= '0;
                        cnt  <= '0;
                    end
                    S_LEN0: len_lo <= bus.in_data;
                    S_LEN1: len    <= len_w;
                    S_DATA: begin
                        // LEN <= DEPTH was checked up front, so the address cannot wrap.
                        we    <= 1'b1;
                        addr  <= cnt[ADDR_W-1:0];
                        wdata <= bus.in_data;
                        sum   <= sum + bus.in_data;
                        cnt   <= cnt_inc;
                    end
                    // A failed check leaves hold set; only a good image releases the core.
                    S_CHK: if (chk_ok) hold <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.cpu_hold  = hold;
    assign bus.load_done = (state == S_DONE);
    assign bus.load_err  = (state == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame parser predicts writes and done/err pulses,
// and a monitor checks them against the DUT outputs as they appear.
module tb_imem_loader;
    localparam int         DEPTH = 128;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef struct {
        int         kind;   // 0 write, 1 done, 2 err
        int         addr;
        logic [7:0] data;
        logic       hold;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  ncmp = 0;
    int  nmis = 0;
    ev_t expq[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: parse the byte stream as frames and list the observable events in order.
    function automatic void model(input logic [7:0] q[$]);
        int i = 0;
        while (i < q.size()) begin
            int len;
            logic [7:0] s;
            if (q[i] != SYNC) begin i++; continue; end
            if (i + 2 >= q.size()) return;
            len = int'(q[i+1]) + 256 * int'(q[i+2]);
            i += 3;
            if (len > DEPTH) begin
                expq.push_back('{2, 0, 8'h00, 1'b1});
                continue;
            end
            s = 8'h00;
            for (int k = 0; k < len; k++) begin
                if (i >= q.size()) return;
                expq.push_back('{0, k, q[i], 1'b1});
                s = s + q[i];
                i++;
            end
            if (i >= q.size()) return;
            if (8'(s + q[i]) == 8'h00) expq.push_back('{1, 0, 8'h00, 1'b0});
            else                       expq.push_back('{2, 0, 8'h00, 1'b1});
            i++;
        end
    endfunction

    // Monitor: every negedge out of reset, consume one expected event per DUT event.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!(bus.load_done || bus.load_err)));
            if (bus.mem_we || bus.load_done || bus.load_err) begin
                int kind;
                kind = bus.mem_we ? 0 : (bus.load_done ? 1 : 2);
                if (expq.size() == 0) begin
                    chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
                end else begin
                    ev_t e;
                    e = expq.pop_front();
                    chk("event_kind", 32'(kind), 32'(e.kind));
                    chk("cpu_hold_at_event", 32'(bus.cpu_hold), 32'(e.hold));
                    if (e.kind == 0) begin
                        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        logic r;
        @(negedge clk);
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            r = bus.in_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'(n), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_stream(input logic [7:0] q[$], input int gapmax);
        model(q);
        foreach (q[i]) send_byte(q[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        idle(3);
    endtask

    function automatic void mk_frame(output logic [7:0] q[$], input int len, input bit good);
        logic [7:0] s = 8'h00;
        q = {};
        q.push_back(SYNC);
        q.push_back(8'(len));
        q.push_back(8'(len >> 8));
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            q.push_back(d);
            s = s + d;
        end
        q.push_back(good ? 8'(-s) : 8'(-s + 8'($urandom_range(1, 255))));
    endfunction

    logic [7:0] t1[$];
    logic [7:0] t2[$];
    logic [7:0] t4[$];
    logic [7:0] fq[$];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        t1 = '{8'hA5, 8'h04, 8'h00, 8'hD3, 8'h07, 8'h56, 8'h00, 8'hD0};
        t2 = '{8'hA5, 8'h04, 8'h00, 8'hD3, 8'h07, 8'h56, 8'h00, 8'hD1};
        t4 = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};

        // Reset values.
        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_outputs", {bus.mem_we, bus.cpu_hold, bus.load_done, bus.load_err, bus.mem_addr, bus.mem_wdata},
            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Good frame, then a bad checksum, then the good frame again.
        run_stream(t1, 0);
        chk("hold_after_done", 32'(bus.cpu_hold), 32'd0);
        run_stream(t2, 0);
        chk("hold_sticky_after_err", 32'(bus.cpu_hold), 32'd1);
        run_stream(t1, 0);
        chk("hold_cleared_by_done", 32'(bus.cpu_hold), 32'd0);

        // Oversize length: error the cycle after LEN_HI, no writes.
        fq = '{8'hA5, 8'h81, 8'h00};
        model(fq);
        foreach (fq[i]) send_byte(fq[i], 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("len129_err_timing", 32'(bus.load_err), 32'd1);
        chk("len129_no_write", 32'(bus.mem_we), 32'd0);
        idle(2);

        // Full-depth image, junk + empty image, gapped repeat of the first frame.
        mk_frame(fq, DEPTH, 1'b1);
        run_stream(fq, 0);
        run_stream(t4, 0);
        run_stream(t1, 3);

        // Randomized frames: junk prefix, lengths across the legal range and past it.
        for (int f = 0; f < 30; f++) begin
            int len;
            logic [7:0] q[$];
            case ($urandom_range(0, 5))
                0:       len = DEPTH;
                1:       len = DEPTH + 1 + int'($urandom_range(0, 300));
                2:       len = 0;
                default: len = int'($urandom_range(1, 24));
            endcase
            mk_frame(fq, len, ($urandom_range(0, 9) < 7));
            q = {};
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == SYNC) j = 8'h3C;
                q.push_back(j);
            end
            // An oversize frame ends at LEN_HI; its trailing bytes would re-parse as junk.
            if (len > DEPTH) fq = fq[0:2];
            q = {q, fq};
            run_stream(q, ($urandom_range(0, 1) != 0) ? 2 : 0);
        end

        // Reset mid-frame after two data bytes.
        fq = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22};
        model(fq);
        foreach (fq[i]) send_byte(fq[i], 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {bus.in_ready, bus.mem_we, bus.cpu_hold, bus.load_done, bus.load_err,
            bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk("midrst_writes_seen", 32'(expq.size()), 32'd0);
        expq = {};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_stream(t1, 1);

        idle(5);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
